// File: rtl/definitions.sv
// Shared constants for the 9-bit core control path: ALU opcodes,
// write-back source codes and the fixed register numbers.
package definitions;
   localparam logic [3:0] kADD = 4'b0000;
   localparam logic [3:0] kSUB = 4'b0001;
   localparam logic [3:0] kLSH = 4'b0010;
   localparam logic [3:0] kRSH = 4'b0011;
   localparam logic [3:0] kORR = 4'b0100;
   localparam logic [3:0] kRXR = 4'b0101;

   localparam logic [2:0] WS_ALU  = 3'b000;
   localparam logic [2:0] WS_MEM  = 3'b001;
   localparam logic [2:0] WS_LUTL = 3'b010;
   localparam logic [2:0] WS_LUTM = 3'b011;
   localparam logic [2:0] WS_IMM  = 3'b100;

   localparam logic [3:0] R0  = 4'd0;
   localparam logic [3:0] R1  = 4'd1;
   localparam logic [3:0] R5  = 4'd5;
   localparam logic [3:0] R6  = 4'd6;
   localparam logic [3:0] R8  = 4'd8;
   localparam logic [3:0] R9  = 4'd9;
   localparam logic [3:0] R10 = 4'd10;
   localparam logic [3:0] R11 = 4'd11;
   localparam logic [3:0] R12 = 4'd12;
   localparam logic [3:0] R15 = 4'd15;
endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder for the 9-bit core.
// Flags DONE separately so the wrapper can decide what to do with it.
module ctrl_decode
   import definitions::*;
(
   input  logic [8:0] instr,
   input  logic [1:0] sub_idx,
   output logic [1:0] pc_sel,
   output logic [2:0] wr_src,
   output logic [3:0] rd_a,
   output logic [3:0] rd_b,
   output logic [3:0] wr_addr,
   output logic [3:0] alu_op,
   output logic [7:0] imm,
   output logic       jmp_eq,
   output logic       jmp_ne,
   output logic       off_en,
   output logic       reg_wr,
   output logic       mem_wr,
   output logic       done
);
   logic [3:0] f_hi;
   logic [3:0] f_mid;
   logic [3:0] f_ld;

   assign f_hi  = {1'b0, instr[5:3]};
   assign f_mid = {1'b0, instr[4:2]};
   assign f_ld  = {1'b0, instr[3:1]};

   always_comb begin
      pc_sel  = 2'b00;
      wr_src  = WS_ALU;
      rd_a    = R0;
      rd_b    = R0;
      wr_addr = R0;
      alu_op  = kADD;
      imm     = 8'h00;
      jmp_eq  = 1'b0;
      jmp_ne  = 1'b0;
      off_en  = 1'b0;
      reg_wr  = 1'b0;
      mem_wr  = 1'b0;
      done    = 1'b0;
      casez (instr)
         9'b000??????: begin
            rd_a = R8; rd_b = {1'b0, instr[2:0]};
            wr_addr = f_hi; alu_op = kLSH; reg_wr = 1'b1;
         end
         9'b001??????: begin
            rd_a = R8; rd_b = {1'b0, instr[2:0]};
            wr_addr = f_hi; alu_op = kRSH; reg_wr = 1'b1;
         end
         9'b01000????: begin
            rd_a = R1; wr_addr = f_ld;
            wr_src = WS_MEM; reg_wr = 1'b1;
         end
         9'b01001????: begin
            rd_a = R1; rd_b = f_ld; mem_wr = 1'b1;
         end
         9'b01010????: begin
            rd_a = R5; wr_addr = f_ld;
            alu_op = {2'b10, sub_idx}; reg_wr = 1'b1;
         end
         9'b01011????: begin
            rd_a = R5; rd_b = R6; wr_addr = f_ld;
            alu_op = {2'b11, sub_idx}; reg_wr = 1'b1;
         end
         9'b0110?????: done = 1'b1;
         9'b0111?????: begin
            rd_a = f_mid; wr_addr = f_mid;
            alu_op = kRXR; reg_wr = 1'b1;
         end
         9'b10000????: begin
            pc_sel = instr[3:2]; jmp_eq = 1'b1;
         end
         9'b10001????: begin
            pc_sel = instr[3:2]; jmp_ne = 1'b1;
         end
         9'b1001?????: begin
            pc_sel = instr[4:3]; rd_b = R8; off_en = instr[2];
         end
         9'b1010?????: begin
            wr_addr = R8; reg_wr = 1'b1;
            // h selects which LUT half and which read port carries s
            if (instr[1]) begin
               rd_b = f_mid; wr_src = WS_LUTM;
            end else begin
               rd_a = f_mid; wr_src = WS_LUTL;
            end
         end
         9'b101100???: begin
            wr_addr = R9; reg_wr = 1'b1;
         end
         9'b101101???: begin
            rd_a = R8; rd_b = R10; wr_addr = R10; reg_wr = 1'b1;
         end
         9'b101110???: begin
            rd_a = R15; rd_b = R11; mem_wr = 1'b1;
         end
         9'b101111???: rd_a = R12;
         9'b1100?????: begin
            rd_a = R8; wr_addr = f_mid; reg_wr = 1'b1;
         end
         9'b1101?????: begin
            rd_a = f_mid; rd_b = {2'b01, instr[1:0]};
            wr_addr = f_mid; alu_op = kORR; reg_wr = 1'b1;
         end
         9'b1110?????: begin
            rd_a = f_mid; rd_b = R8; wr_addr = f_mid;
            alu_op = instr[1] ? kSUB : kADD; reg_wr = 1'b1;
         end
         default: begin
            imm = {3'b000, instr[4:0]};
            wr_addr = R8; wr_src = WS_IMM; reg_wr = 1'b1;
         end
      endcase
   end
endmodule

// File: rtl/ctrl.sv
// Control unit top: decoder plus the halt flag driving Ack.
// Halt logic exists only when CTRL_HALT_EN is defined.
module ctrl
   import definitions::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic [8:0] Instruction,
   input  logic [1:0] SubstringIndex,
   output logic [1:0] PCRegSelect,
   output logic [2:0] WriteSource,
   output logic [3:0] ReadRegAddrA,
   output logic [3:0] ReadRegAddrB,
   output logic [3:0] WriteRegAddr,
   output logic [3:0] ALUOp,
   output logic [7:0] ImmOut,
   output logic       JumpEqual,
   output logic       JumpNotEqual,
   output logic       OffsetEn,
   output logic       RegWrEn,
   output logic       MemWrEn,
   output logic       Ack
);
   logic reg_wr;
   logic mem_wr;
   logic jmp_eq;
   logic jmp_ne;
   logic done;

   ctrl_decode u_dec (
      .instr   (Instruction),
      .sub_idx (SubstringIndex),
      .pc_sel  (PCRegSelect),
      .wr_src  (WriteSource),
      .rd_a    (ReadRegAddrA),
      .rd_b    (ReadRegAddrB),
      .wr_addr (WriteRegAddr),
      .alu_op  (ALUOp),
      .imm     (ImmOut),
      .jmp_eq  (jmp_eq),
      .jmp_ne  (jmp_ne),
      .off_en  (OffsetEn),
      .reg_wr  (reg_wr),
      .mem_wr  (mem_wr),
      .done    (done)
   );

`ifdef CTRL_HALT_EN
   logic halt_q;
   logic halt_d;

   always_comb halt_d = halt_q | done;

   always_ff @(posedge Clk) begin
      if (!Reset) halt_q <= 1'b0;
      else        halt_q <= halt_d;
   end

   assign Ack          = halt_q;
   assign RegWrEn      = reg_wr & ~halt_q;
   assign MemWrEn      = mem_wr & ~halt_q;
   assign JumpEqual    = jmp_eq & ~halt_q;
   assign JumpNotEqual = jmp_ne & ~halt_q;
`else
   logic unused_ok;
   assign unused_ok    = ^{Clk, Reset, done};
   assign Ack          = 1'b0;
   assign RegWrEn      = reg_wr;
   assign MemWrEn      = mem_wr;
   assign JumpEqual    = jmp_eq;
   assign JumpNotEqual = jmp_ne;
`endif
endmodule

// File: tb/tb_ctrl.sv
// Randomized bench for ctrl against a field-level reference model.
// Halt checks follow whichever CTRL_HALT_EN build is compiled.
module tb_ctrl;
   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic [8:0] Instruction = 9'd0;
   logic [1:0] SubstringIndex = 2'd0;
   logic [1:0] PCRegSelect;
   logic [2:0] WriteSource;
   logic [3:0] ReadRegAddrA, ReadRegAddrB, WriteRegAddr, ALUOp;
   logic [7:0] ImmOut;
   logic       JumpEqual, JumpNotEqual, OffsetEn, RegWrEn, MemWrEn, Ack;

   int total = 0;
   int bad = 0;
   bit halt_m = 1'b0;
`ifdef CTRL_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   ctrl dut (
      .Clk(Clk), .Reset(Reset), .Instruction(Instruction),
      .SubstringIndex(SubstringIndex), .PCRegSelect(PCRegSelect),
      .WriteSource(WriteSource), .ReadRegAddrA(ReadRegAddrA),
      .ReadRegAddrB(ReadRegAddrB), .WriteRegAddr(WriteRegAddr),
      .ALUOp(ALUOp), .ImmOut(ImmOut), .JumpEqual(JumpEqual),
      .JumpNotEqual(JumpNotEqual), .OffsetEn(OffsetEn),
      .RegWrEn(RegWrEn), .MemWrEn(MemWrEn), .Ack(Ack)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [34:0] got,
                        input logic [34:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [34:0] model(input int u, input int si,
                                         input bit halt);
      int a = 0, b = 0, w = 0, op = 0, ws = 0, imm = 0, pc = 0;
      bit je = 0, jne = 0, off = 0, rw = 0, mw = 0;
      if (u < 64) begin
         a = 8; b = u % 8; w = (u / 8) % 8; op = 2; rw = 1;
      end else if (u < 128) begin
         a = 8; b = u % 8; w = (u / 8) % 8; op = 3; rw = 1;
      end else if (u / 16 == 8) begin
         a = 1; w = (u / 2) % 8; ws = 1; rw = 1;
      end else if (u / 16 == 9) begin
         a = 1; b = (u / 2) % 8; mw = 1;
      end else if (u / 16 == 10) begin
         a = 5; w = (u / 2) % 8; op = 8 + si; rw = 1;
      end else if (u / 16 == 11) begin
         a = 5; b = 6; w = (u / 2) % 8; op = 12 + si; rw = 1;
      end else if (u / 32 == 6) begin
      end else if (u / 32 == 7) begin
         a = (u / 4) % 8; w = a; op = 5; rw = 1;
      end else if (u / 16 == 16) begin
         pc = (u / 4) % 4; je = 1;
      end else if (u / 16 == 17) begin
         pc = (u / 4) % 4; jne = 1;
      end else if (u / 32 == 9) begin
         pc = (u / 8) % 4; b = 8; off = bit'((u / 4) % 2);
      end else if (u / 32 == 10) begin
         w = 8; rw = 1;
         if ((u / 2) % 2 == 1) begin b = (u / 4) % 8; ws = 3; end
         else begin a = (u / 4) % 8; ws = 2; end
      end else if (u / 32 == 11) begin
         case ((u / 8) % 4)
            0: begin w = 9; rw = 1; end
            1: begin a = 8; b = 10; w = 10; rw = 1; end
            2: begin a = 15; b = 11; mw = 1; end
            default: a = 12;
         endcase
      end else if (u / 32 == 12) begin
         a = 8; w = (u / 4) % 8; rw = 1;
      end else if (u / 32 == 13) begin
         a = (u / 4) % 8; b = 4 + u % 4; w = a; op = 4; rw = 1;
      end else if (u / 32 == 14) begin
         a = (u / 4) % 8; b = 8; w = a; op = (u / 2) % 2; rw = 1;
      end else begin
         imm = u % 32; w = 8; ws = 4; rw = 1;
      end
      if (halt) begin je = 0; jne = 0; rw = 0; mw = 0; end
      return {2'(pc), 3'(ws), 4'(a), 4'(b), 4'(w), 4'(op), 8'(imm),
              je, jne, off, rw, mw, halt};
   endfunction

   function automatic logic [34:0] observed();
      return {PCRegSelect, WriteSource, ReadRegAddrA, ReadRegAddrB,
              WriteRegAddr, ALUOp, ImmOut, JumpEqual, JumpNotEqual,
              OffsetEn, RegWrEn, MemWrEn, Ack};
   endfunction

   task automatic step(input string tag, input int ins, input int si,
                       input bit rst);
      @(negedge Clk);
      Instruction = 9'(ins);
      SubstringIndex = 2'(si);
      Reset = rst;
      #1 check(tag, observed(), model(ins, si, halt_m));
      @(posedge Clk);
      if (!rst) halt_m = 1'b0;
      else if (HALT_EN && ins / 32 == 6) halt_m = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge Clk);
      step("reset", 9'b1111_00000, 0, 1'b0);
      check("reset_ack", 35'(Ack), 35'd0);
      step("lsh", 9'b000_100_101, 0, 1'b1);
      check("lsh_a", 35'(ReadRegAddrA), 35'd8);
      step("dbs", 9'b01011_011_0, 3, 1'b1);
      check("dbs_op", 35'(ALUOp), 35'hF);
      step("spc", 9'b1001_01_1_00, 0, 1'b1);
      step("lut_hi", 9'b1010_011_1_0, 0, 1'b1);
      step("clr", 9'b1011_00_000, 0, 1'b1);
      step("inc", 9'b1011_01_101, 0, 1'b1);
      step("sti", 9'b1011_10_010, 0, 1'b1);
      step("tst", 9'b1011_11_111, 0, 1'b1);
      step("pre_done", 9'b0110_00000, 0, 1'b0);
      step("done", 9'b0110_10101, 0, 1'b1);
      @(negedge Clk);
      #1 check("ack_after_done", 35'(Ack), 35'(HALT_EN));
      step("mov_halted", 9'b1111_11110, 0, 1'b1);
      check("mov_imm", 35'(ImmOut), 35'h1E);
      check("mov_wr", 35'(RegWrEn), 35'(!HALT_EN));
      step("rst_again", 9'b10000_10_00, 0, 1'b0);
      @(negedge Clk);
      #1 check("ack_cleared", 35'(Ack), 35'd0);
      for (int n = 0; n < 400; n++) begin
         step("rand", int'($urandom % 512), int'($urandom % 4),
              ($urandom % 10) != 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ctrl.md
# ctrl

Instruction decoder and control unit of the 9-bit processor core. It maps the current 9-bit instruction to register-file addresses, ALU opcode, write-back source, immediate, memory and register write enables, and jump/PC-register controls. Every output except Ack is combinational. A one-bit halt register produces the Ack "program done" signal.

## Interface
- No parameters.
- Clk  in  1  system clock. Only the halt register uses it.
- Reset  in  1  reset. Synchronous, active-low.
- Instruction  in  9  current instruction.
- SubstringIndex  in  2  substring position used by sbs/dbs.
- PCRegSelect  out  2  PC-register index for jumps and PC stores.
- WriteSource  out  3  write-back mux select: 000 ALU, 001 data memory, 010 LUT LSW, 011 LUT MSW, 100 ImmOut.
- ReadRegAddrA / ReadRegAddrB  out  4 each  register-file read ports. r0 always reads 0.
- WriteRegAddr  out  4  register-file write address.
- ALUOp  out  4  ALU operation.
- ImmOut  out  8  immediate value.
- JumpEqual, JumpNotEqual, OffsetEn, RegWrEn, MemWrEn, Ack  out  1 each.

## Operation
Defaults for any field an instruction does not name: A=0, B=0, W=0, ALUOp=kADD, WriteSource=000, ImmOut=0, PCRegSelect=00, all enables 0. Notation: d/s = 3-bit field, zero-extended to 4 bits.

- 000_ddd_sss LSH: A=r8, B=s, W=d, kLSH, RegWr.
- 001_ddd_sss RSH: A=r8, B=s, W=d, kRSH, RegWr.
- 01000_ddd_x LD: A=r1, W=d, WS=001, RegWr.
- 01001_sss_x ST: A=r1, B=s, MemWr.
- 01010_ddd_x SBS: A=r5, W=d, ALUOp={10,SubstringIndex}, RegWr.
- 01011_ddd_x DBS: A=r5, B=r6, W=d, ALUOp={11,SubstringIndex}, RegWr.
- 0110_xxxxx DONE: no writes. Sets the halt flag.
- 0111_ddd_xx RXR: A=d, W=d, kRXR, RegWr.
- 10000_pp_xx JE: PCRegSelect=pp, JumpEqual.
- 10001_pp_xx JNE: PCRegSelect=pp, JumpNotEqual.
- 1001_pp_o_xx SPC: PCRegSelect=pp, B=r8, OffsetEn=o.
- 1010_sss_h_x LUT: W=r8, RegWr. h=0: A=s, WS=010. h=1: B=s, WS=011.
- 1011_00_xxx CLR: A=r0, B=r0, W=r9, kADD, RegWr.
- 1011_01_xxx INC: A=r8, B=r10, W=r10, kADD, RegWr.
- 1011_10_xxx STI: A=r15, B=r11, MemWr.
- 1011_11_xxx TST: A=r12, B=r0, kADD, no write (sets the zero flag only).
- 1100_ddd_xx CPY: A=r8, B=r0, W=d, kADD, RegWr.
- 1101_ddd_ss ORR: A=d, B={01,ss}, W=d, kORR, RegWr.
- 1110_ddd_f_x ADD/SUB: A=d, B=r8, W=d, f=0 kADD / f=1 kSUB, RegWr.
- 1111_iiiii MOV: ImmOut={000,iiiii}, W=r8, WS=100, RegWr.

Halt rule: while the halt flag is set, RegWrEn, MemWrEn, JumpEqual and JumpNotEqual are forced to 0.

## Timing
- Decode is purely combinational and settles within the same cycle as Instruction changes. No latency.
- Halt flag:
  - Reset low at a Clk rising edge clears it. Reset has priority over a simultaneous DONE.
  - When Reset is high and DONE is decoded, it sets at the next rising edge and stays set until reset.
  - Ack equals the flag, so Ack rises one cycle after DONE is presented. Ack is 0 from reset.
- Reset asserted mid-program clears Ack on the next edge. Decode outputs do not depend on Reset.

## Configuration
- CTRL_HALT_EN defined: DONE decode, halt flag, Ack and write/jump masking are all present.
- CTRL_HALT_EN undefined: 0110_xxxxx is a NOP (all defaults), Ack is tied to 0, there is no register, and Clk/Reset are unused.

## Structure
- Package `definitions` holds the ALUOp constants: kADD=0000, kSUB=0001, kLSH=0010, kRSH=0011, kORR=0100, kRXR=0101. Substring ops occupy 10xx and 11xx.
- It also holds the WriteSource codes and the fixed register numbers (r1, r5, r6, r8–r12, r15).
- One natural sub-module: `ctrl_decode`, the combinational decoder. `ctrl` wraps it with the halt register.

## Test plan
- 000_100_101 -> A=1000, B=0101, W=0100, ALUOp=kLSH, RegWrEn=1, WS=000.
- 01011_011_0 with SubstringIndex=11 -> A=0101, B=0110, W=0011, ALUOp=1111, RegWrEn=1.
- 1001_01_1_00 -> PCRegSelect=01, B=1000, OffsetEn=1, RegWrEn=0, MemWrEn=0.
- 1010_011_1_0 -> WS=011, B=0011, W=1000, RegWrEn=1.
- Each 1011_xx encoding:
  - 00: W=1001, A=B=0.
  - 01: A=1000, B=W=1010.
  - 10: A=1111, B=1011, MemWrEn=1.
  - 11: A=1100, B=0, RegWrEn=0.
- Reset low one cycle, then DONE -> Ack 0 until the next edge, then 1. A following 1111_11110 yields RegWrEn=0 and ImmOut=00011110. Reset low again -> Ack 0.
